// File: rtl/cond_pkg.sv
// Shared definitions for the input conditioner: counter sizing, stage limit and edge pulse type.
package cond_pkg;

    localparam int MAX_SYNC_STAGES = 4;

    typedef struct packed {
        logic rise;
        logic fall;
    } cond_edge_t;

    // Debounce counter width for a D-cycle filter; never narrower than one bit.
    function automatic int cnt_width(input int d);
        int w;
        w = 1;
        if (d > 0) begin
            w = $clog2(d + 1);
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cond_channel.sv
// One conditioned input: synchroniser chain, debounce filter, Out flop and edge pulses.
// Edge pulse registers exist only when INPUT_CONDITIONER_EDGE_EN is defined.
module cond_channel
    import cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES:0]   chain;
    logic                   synced;
    logic                   outReg;

    // chain[0] is the raw pin, chain[k] is sync stage k-1, the top bit is the synced level.
    assign chain  = {sync, raw};
    assign synced = chain[SYNC_STAGES];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync <= chain[SYNC_STAGES-1:0];
        end
    end

`ifdef INPUT_CONDITIONER_EDGE_EN
    logic outNext;
`endif

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign outReg = synced;
`ifdef INPUT_CONDITIONER_EDGE_EN
            assign outNext = chain[SYNC_STAGES-1];
`endif
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;
            logic             outFlop;

            // Any cycle where synced agrees with Out throws away the partial count.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    cnt     <= '0;
                    outFlop <= RESET_BIT;
                end else if (synced != outFlop) begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        outFlop <= synced;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end

            assign outReg = outFlop;
`ifdef INPUT_CONDITIONER_EDGE_EN
            assign outNext = ((synced != outFlop) && (cnt == LAST)) ? synced : outFlop;
`endif
        end
    endgenerate

    assign out = outReg;

`ifdef INPUT_CONDITIONER_EDGE_EN
    cond_edge_t edgeReg;

    // Pulses are computed from the value Out is about to take, so they line up with the change.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            edgeReg <= '0;
        end else begin
            edgeReg.rise <= outNext & ~outReg;
            edgeReg.fall <= ~outNext & outReg;
        end
    end

    assign rise = edgeReg.rise;
    assign fall = edgeReg.fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel synchroniser and debouncer; each channel is an independent cond_channel.
// Define INPUT_CONDITIONER_EDGE_EN to build the Rise/Fall pulse outputs.
module input_conditioner
    import cond_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter logic [CHANNELS-1:0] RESET_VAL       = '0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] IN,
    output logic [CHANNELS-1:0] Out,
    output logic [CHANNELS-1:0] Rise,
    output logic [CHANNELS-1:0] Fall
);

    // Out-of-range stage counts are clamped rather than producing a broken chain.
    localparam int STAGES = (SYNC_STAGES < 1) ? 1 :
                            (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;
    localparam int DEBOUNCE = (DEBOUNCE_CYCLES < 0) ? 0 : DEBOUNCE_CYCLES;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            cond_channel #(
                .SYNC_STAGES    (STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE),
                .RESET_BIT      (RESET_VAL[i])
            ) u_channel (
                .Clk  (Clk),
                .Reset(Reset),
                .raw  (IN[i]),
                .out  (Out[i]),
                .rise (Rise[i]),
                .fall (Fall[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios followed by random toggling,
// compared against a sliding-window reference model.
module tb_input_conditioner;

    localparam int             CH = 4;
    localparam int             SS = 2;
    localparam int             DB = 4;
    localparam logic [CH-1:0]  RV = 4'b1010;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [CH-1:0] IN;
    logic [CH-1:0] Out;
    logic [CH-1:0] Rise;
    logic [CH-1:0] Fall;

    int compared   = 0;
    int mismatched = 0;
    int stepNo     = 0;

    // Reference model state: input delay line, per-channel history of synced samples.
    logic [CH-1:0] pipe [SS];
    bit            hist [CH][$];
    logic [CH-1:0] mOut;
    logic [CH-1:0] mRise;
    logic [CH-1:0] mFall;

    input_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB),
        .RESET_VAL      (RV)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .IN   (IN),
        .Out  (Out),
        .Rise (Rise),
        .Fall (Fall)
    );

    always #5 Clk = ~Clk;

    // Out flips when the last DB synced samples since reset all disagree with it.
    task automatic modelEdge(input logic [CH-1:0] inS, input logic rstS);
        logic [CH-1:0] synced;
        logic [CH-1:0] nextOut;
        bit            allDiff;
        if (rstS) begin
            for (int k = 0; k < SS; k++) pipe[k] = RV;
            for (int i = 0; i < CH; i++) hist[i].delete();
            mOut  = RV;
            mRise = '0;
            mFall = '0;
        end else begin
            synced = pipe[SS-1];
            for (int k = SS - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = inS;
            nextOut = mOut;
            for (int i = 0; i < CH; i++) begin
                hist[i].push_back(synced[i]);
                if (hist[i].size() > DB) void'(hist[i].pop_front());
                if (hist[i].size() == DB) begin
                    allDiff = 1'b1;
                    foreach (hist[i][j]) begin
                        if (hist[i][j] == mOut[i]) allDiff = 1'b0;
                    end
                    if (allDiff) nextOut[i] = ~mOut[i];
                end
            end
            mRise = nextOut & ~mOut;
            mFall = ~nextOut & mOut;
            mOut  = nextOut;
        end
    endtask

    task automatic checkOutput();
        logic [CH-1:0] expRise;
        logic [CH-1:0] expFall;
`ifdef INPUT_CONDITIONER_EDGE_EN
        expRise = mRise;
        expFall = mFall;
`else
        expRise = '0;
        expFall = '0;
`endif
        compared++;
        assert (Out === mOut) else begin
            mismatched++;
            $error("[TB] FAIL out step=%0d actual=%b expected=%b", stepNo, Out, mOut);
        end
        compared++;
        assert (Rise === expRise) else begin
            mismatched++;
            $error("[TB] FAIL rise step=%0d actual=%b expected=%b", stepNo, Rise, expRise);
        end
        compared++;
        assert (Fall === expFall) else begin
            mismatched++;
            $error("[TB] FAIL fall step=%0d actual=%b expected=%b", stepNo, Fall, expFall);
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] inVal, input logic rstVal);
        IN    = inVal;
        Reset = rstVal;
        @(posedge Clk);
        modelEdge(inVal, rstVal);
        stepNo++;
        #1;
        checkOutput();
    endtask

    initial begin
        logic [CH-1:0] rin;
        logic [CH-1:0] mask;
        logic          rst;

        $display("[TB] scenario 1: reset held with IN opposite to reset value");
        for (int n = 0; n < 3; n++) applyStimulus(4'b0101, 1'b1);
        for (int n = 0; n < 6; n++) applyStimulus(4'b1010, 1'b0);

        $display("[TB] scenario 2: channel 0 rises, latency check");
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(4'b1011, 1'b0);
            if (n == 5) begin
                compared++;
                assert (Out[0] === 1'b0) else begin
                    mismatched++;
                    $error("[TB] FAIL latency_early actual=%b expected=0", Out[0]);
                end
            end
            if (n == 6) begin
                compared++;
                assert (Out[0] === 1'b1) else begin
                    mismatched++;
                    $error("[TB] FAIL latency_edge6 actual=%b expected=1", Out[0]);
                end
            end
        end

        $display("[TB] scenario 3: short and just-long-enough pulses on channel 2");
        for (int n = 0; n < 3; n++) applyStimulus(4'b1111, 1'b0);
        for (int n = 0; n < 8; n++) applyStimulus(4'b1011, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(4'b1111, 1'b0);
        for (int n = 0; n < 10; n++) applyStimulus(4'b1011, 1'b0);

        $display("[TB] scenario 4: simultaneous fall on channel 1 and rise on channel 2");
        for (int n = 0; n < 8; n++) applyStimulus(4'b1101, 1'b0);

        $display("[TB] scenario 5: reset in the middle of a channel 3 count");
        for (int n = 0; n < 5; n++) applyStimulus(4'b0101, 1'b0);
        applyStimulus(4'b0101, 1'b1);
        compared++;
        assert (Out[3] === 1'b1) else begin
            mismatched++;
            $error("[TB] FAIL reset_midcount actual=%b expected=1", Out[3]);
        end
        for (int n = 0; n < 8; n++) applyStimulus(4'b0101, 1'b0);

        $display("[TB] random phase");
        rin = 4'b0101;
        for (int n = 0; n < 600; n++) begin
            mask = '0;
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) mask[i] = 1'b1;
            end
            rin = rin ^ mask;
            rst = ($urandom_range(0, 63) == 0);
            applyStimulus(rin, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
